// File: rtl/enable_prescaler.sv
// Strobe generator feeding the enable of the 8-bit enabled counter.
// Emits one-cycle enable strobes every div_value clocks, as a burst or continuously.
module enable_prescaler #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] div_value,
  input  logic [WIDTH-1:0] burst_len,
  output logic             enable_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] pulse_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] pre_cnt;
  logic [WIDTH-1:0] div_reg;
  logic [WIDTH-1:0] burst_reg;
  logic [WIDTH-1:0] pulse_inc;
  logic             launch;
  logic             strobe;
  logic             last_strobe;

  assign pulse_inc = pulse_count + ONE;

  always_comb begin
    state_next  = state;
    launch      = 1'b0;
    strobe      = 1'b0;
    last_strobe = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          launch     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_next = IDLE;
        end else if (pre_cnt == div_reg - ONE) begin
          strobe = 1'b1;
          // A zero burst length never terminates, so pulse_count may wrap freely
          if ((burst_reg != '0) && (pulse_inc == burst_reg)) begin
            last_strobe = 1'b1;
            state_next  = DONE;
          end
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pre_cnt     <= '0;
      div_reg     <= '0;
      burst_reg   <= '0;
      pulse_count <= '0;
      enable_out  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      enable_out <= strobe;
      busy       <= (state_next == RUN);
      done       <= (state == DONE);
      if (launch) begin
        div_reg     <= (div_value == '0) ? ONE : div_value;
        burst_reg   <= burst_len;
        pre_cnt     <= '0;
        pulse_count <= '0;
      end else if (state == RUN && !stop) begin
        pre_cnt <= strobe ? '0 : pre_cnt + ONE;
        if (strobe) begin
          pulse_count <= pulse_inc;
        end
      end
      if (last_strobe) begin
        pre_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_enable_prescaler.sv
// Directed self-checking bench for enable_prescaler.
// Inputs change and outputs are sampled on the falling edge.
module tb_enable_prescaler;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic [7:0] div_value;
  logic [7:0] burst_len;
  logic       enable_out;
  logic       busy;
  logic       done;
  logic [7:0] pulse_count;

  int checks = 0;
  int errors = 0;
  int ds_count;

  enable_prescaler #(.WIDTH(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .div_value  (div_value),
    .burst_len  (burst_len),
    .enable_out (enable_out),
    .busy       (busy),
    .done       (done),
    .pulse_count(pulse_count)
  );

  always #5 clock = ~clock;

  task automatic applyStimulus(input logic r, input logic s, input logic p,
                               input logic [7:0] d, input logic [7:0] b);
    reset     = r;
    start     = s;
    stop      = p;
    div_value = d;
    burst_len = b;
    @(negedge clock);
  endtask

  task automatic checkOne(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic en, input logic bsy,
                             input logic dn, input logic [7:0] pc);
    checkOne($sformatf("%s.enable_out", tag), {7'd0, enable_out}, {7'd0, en});
    checkOne($sformatf("%s.busy", tag), {7'd0, busy}, {7'd0, bsy});
    checkOne($sformatf("%s.done", tag), {7'd0, done}, {7'd0, dn});
    checkOne($sformatf("%s.pulse_count", tag), pulse_count, pc);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; div_value = '0; burst_len = '0;

    // Reset held two cycles with start asserted
    applyStimulus(1, 1, 0, 8'd4, 8'd3);
    applyStimulus(1, 1, 0, 8'd4, 8'd3);
    checkOutput("reset", 0, 0, 0, 8'd0);
    applyStimulus(0, 0, 0, 8'd4, 8'd3);
    checkOutput("post_reset", 0, 0, 0, 8'd0);
    applyStimulus(0, 1, 1, 8'd4, 8'd3);
    checkOutput("start_and_stop", 0, 0, 0, 8'd0);

    // div=4 burst=3; stop during the DONE cycle must not matter
    applyStimulus(0, 1, 0, 8'd4, 8'd3);
    checkOutput("b1.k", 0, 1, 0, 8'd0);
    for (int j = 1; j <= 14; j++) begin
      applyStimulus(0, 0, (j == 13), 8'd9, 8'd9);
      checkOutput($sformatf("b1.k+%0d", j), (j % 4 == 0) && (j <= 12), (j < 12),
                  (j == 13), (j > 12) ? 8'd3 : 8'(j / 4));
    end

    // Continuous, div=0 treated as 1, pulse_count wraps after 256
    applyStimulus(0, 1, 0, 8'd0, 8'd0);
    checkOutput("cont.k", 0, 1, 0, 8'd0);
    for (int j = 1; j <= 256; j++) begin
      applyStimulus(0, 0, 0, 8'd0, 8'd0);
      checkOutput($sformatf("cont.k+%0d", j), 1, 1, 0, 8'(j % 256));
    end
    applyStimulus(0, 0, 1, 8'd0, 8'd0);
    checkOutput("cont.stop", 0, 0, 0, 8'd0);
    applyStimulus(0, 0, 0, 8'd0, 8'd0);
    checkOutput("cont.after", 0, 0, 0, 8'd0);

    // Stop on the edge where a strobe is due
    applyStimulus(0, 1, 0, 8'd5, 8'd10);
    checkOutput("stp.k", 0, 1, 0, 8'd0);
    for (int j = 1; j <= 9; j++) begin
      applyStimulus(0, 0, 0, 8'd5, 8'd10);
      checkOutput($sformatf("stp.k+%0d", j), (j == 5), 1, 0, (j >= 5) ? 8'd1 : 8'd0);
    end
    applyStimulus(0, 0, 1, 8'd5, 8'd10);
    checkOutput("stp.k+10", 0, 0, 0, 8'd1);
    applyStimulus(0, 0, 0, 8'd5, 8'd10);
    checkOutput("stp.k+11", 0, 0, 0, 8'd1);

    // Reset mid-burst, then a fresh full burst
    applyStimulus(0, 1, 0, 8'd3, 8'd4);
    checkOutput("rst.k", 0, 1, 0, 8'd0);
    for (int j = 1; j <= 6; j++) begin
      applyStimulus(0, 0, 0, 8'd3, 8'd4);
      checkOutput($sformatf("rst.k+%0d", j), (j % 3 == 0), 1, 0, 8'(j / 3));
    end
    applyStimulus(1, 0, 0, 8'd3, 8'd4);
    checkOutput("rst.k+7", 0, 0, 0, 8'd0);
    applyStimulus(0, 1, 0, 8'd3, 8'd4);
    checkOutput("fresh.k", 0, 1, 0, 8'd0);
    for (int j = 1; j <= 14; j++) begin
      applyStimulus(0, 0, 0, 8'd3, 8'd4);
      checkOutput($sformatf("fresh.k+%0d", j), (j % 3 == 0) && (j <= 12), (j < 12),
                  (j == 13), (j > 12) ? 8'd4 : 8'(j / 3));
    end

    // Re-pulsed start and changed div mid-run; downstream counter advances by N
    applyStimulus(0, 1, 0, 8'd2, 8'd5);
    checkOutput("rep.k", 0, 1, 0, 8'd0);
    ds_count = 0;
    for (int j = 1; j <= 12; j++) begin
      applyStimulus(0, (j == 3), 0, 8'd7, 8'd1);
      if (enable_out) ds_count++;
      checkOutput($sformatf("rep.k+%0d", j), (j % 2 == 0) && (j <= 10), (j < 10),
                  (j == 11), (j > 10) ? 8'd5 : 8'(j / 2));
    end
    checkOne("rep.downstream_count", 8'(ds_count), 8'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
